// File: rtl/cv32e40p_pkg.sv
// Shared types and limits for the instruction-side memory responder.
package cv32e40p_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } instr_resp_t;

    localparam int INSTR_MEM_MAX_LATENCY     = 4;
    localparam int INSTR_MEM_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/cv32e40p_instr_mem_responder_if.sv
// Instruction fetch bus (req/gnt/rvalid, no rready) between the core and its instruction memory.
interface cv32e40p_instr_mem_responder_if;
    import cv32e40p_pkg::*;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

endinterface

// File: rtl/cv32e40p_instr_ram.sv
// Simple dual-port word RAM: one synchronous read port, one write port, read-before-write.
module cv32e40p_instr_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Both ports update with non-blocking assignments, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cv32e40p_instr_mem_responder.sv
// Instruction memory responder: grants fetches, reads a preloadable RAM and returns
// in-order responses exactly LATENCY cycles after each accept.
module cv32e40p_instr_mem_responder
    import cv32e40p_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 12,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cv32e40p_instr_mem_responder_if.slave bus,
    input  logic                          gnt_stall_i,
    input  logic                          load_we_i,
    input  logic [ADDR_WIDTH-1:0]         load_addr_i,
    input  logic [31:0]                   load_wdata_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (LATENCY < 1 || LATENCY > INSTR_MEM_MAX_LATENCY) begin : g_chk_latency
        $error("cv32e40p_instr_mem_responder: LATENCY must be in 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > INSTR_MEM_MAX_OUTSTANDING) begin : g_chk_outstanding
        $error("cv32e40p_instr_mem_responder: MAX_OUTSTANDING must be in 1..4");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base
        $error("cv32e40p_instr_mem_responder: BASE_ADDR must be word aligned");
    end

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  dec_err;
    logic                  gnt;
    logic                  accept;
    logic                  rvalid;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_busy;
    logic [LATENCY:1]      vld_pipe;
    logic                  err_s1;
    logic [31:0]           ram_rdata;
    instr_resp_t           resp_s1;
    instr_resp_t           resp_out;

    // Since addr >= BASE_ADDR is checked separately, the subtraction never wraps for legal hits.
    assign offset  = bus.instr_addr_i - BASE_ADDR;
    assign idx     = offset[ADDR_WIDTH+1:2];
    assign dec_err = (offset[1:0] != 2'b00)
                   || (bus.instr_addr_i < BASE_ADDR)
                   || (offset[31:ADDR_WIDTH+2] != '0);

    // A slot frees in the same cycle its response leaves, which keeps 1/cycle streaming
    // when MAX_OUTSTANDING >= LATENCY.
    assign rvalid   = vld_pipe[LATENCY];
    assign cnt_busy = cnt - CW'(rvalid);
    assign gnt      = bus.instr_req_i & ~gnt_stall_i & ~load_we_i
                    & (cnt_busy < CW'(MAX_OUTSTANDING));
    assign accept   = bus.instr_req_i & gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept && !rvalid) begin
            cnt <= cnt + CW'(1);
        end else if (!accept && rvalid) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_s1   <= 1'b0;
        end else begin
            vld_pipe[1] <= accept;
            if (accept) err_s1 <= dec_err;
            for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    cv32e40p_instr_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .re    (accept & ~dec_err),
        .raddr (idx),
        .rdata (ram_rdata),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_wdata_i)
    );

    // Error accepts skip the RAM read, so the stale RAM output is masked here.
    assign resp_s1.err   = err_s1;
    assign resp_s1.rdata = err_s1 ? '0 : ram_rdata;

    if (LATENCY == 1) begin : g_pipe_l1
        assign resp_out = resp_s1;
    end else begin : g_pipe_ln
        instr_resp_t resp_pipe [LATENCY:2];

        always_ff @(posedge clk) begin
            resp_pipe[2] <= resp_s1;
            for (int i = 3; i <= LATENCY; i++) resp_pipe[i] <= resp_pipe[i-1];
        end

        assign resp_out = resp_pipe[LATENCY];
    end

    assign bus.instr_gnt_o    = gnt;
    assign bus.instr_rvalid_o = rvalid;
    assign bus.instr_err_o    = rvalid & resp_out.err;
    assign bus.instr_rdata_o  = rvalid ? resp_out.rdata : '0;

    cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CW'(MAX_OUTSTANDING));
    cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rvalid && (cnt == '0)));

endmodule

// File: tb/tb_cv32e40p_instr_mem_responder.sv
// Bench for the instruction memory responder: four configurations share one directed stimulus,
// a queue-based model checks every cycle, and directed literal checks pin key cycles.
module tb_cv32e40p_instr_mem_responder;
    import cv32e40p_pkg::*;

    localparam int NI = 4;
    localparam int AW = 12;
    // Instances: 0 = L1/M2, 1 = L2/M2, 2 = L3/M1, 3 = L3/M4
    localparam logic [NI-1:0][3:0] LAT_P = {4'd3, 4'd3, 4'd2, 4'd1};
    localparam logic [NI-1:0][3:0] MO_P  = {4'd4, 4'd1, 4'd2, 4'd2};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [31:0]   addr;
    logic          stall;
    logic          lwe;
    logic [AW-1:0] laddr;
    logic [31:0]   lwdata;

    logic          gnt_v [NI];
    logic          rv_v  [NI];
    logic          err_v [NI];
    logic [31:0]   rd_v  [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        cv32e40p_instr_mem_responder_if bus ();
        assign bus.instr_req_i  = req;
        assign bus.instr_addr_i = addr;
        assign gnt_v[k] = bus.instr_gnt_o;
        assign rv_v[k]  = bus.instr_rvalid_o;
        assign err_v[k] = bus.instr_err_o;
        assign rd_v[k]  = bus.instr_rdata_o;

        cv32e40p_instr_mem_responder #(
            .ADDR_WIDTH      (AW),
            .LATENCY         (int'(LAT_P[k])),
            .MAX_OUTSTANDING (int'(MO_P[k])),
            .BASE_ADDR       (32'h0000_0000)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .bus          (bus.slave),
            .gnt_stall_i  (stall),
            .load_we_i    (lwe),
            .load_addr_i  (laddr),
            .load_wdata_i (lwdata)
        );
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: one FIFO of pending responses per instance, each tagged with its due cycle.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } ent_t;

    ent_t        q [NI][$];
    logic [31:0] mem [2**AW];
    int          cyc = 0;

    always @(negedge clk) begin
        bit          head;
        int          busy;
        bit          e_gnt;
        bit          e_err;
        logic [31:0] e_data;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                q[k].delete();
                chk1($sformatf("m_rst_rvalid%0d", k), rv_v[k], 1'b0);
                chk1($sformatf("m_rst_err%0d", k), err_v[k], 1'b0);
                chk32($sformatf("m_rst_rdata%0d", k), rd_v[k], 32'h0);
            end else begin
                head  = (q[k].size() > 0) && (q[k][0].due == cyc);
                busy  = q[k].size() - (head ? 1 : 0);
                e_gnt = req && !stall && !lwe && (busy < int'(MO_P[k]));
                chk1($sformatf("m_gnt%0d@%0d", k, cyc), gnt_v[k], e_gnt);
                chk1($sformatf("m_rvalid%0d@%0d", k, cyc), rv_v[k], head);
                if (head) begin
                    chk1($sformatf("m_err%0d@%0d", k, cyc), err_v[k], q[k][0].err);
                    chk32($sformatf("m_rdata%0d@%0d", k, cyc), rd_v[k], q[k][0].data);
                    void'(q[k].pop_front());
                end
                if (e_gnt) begin
                    e_err  = (addr % 4 != 0) || (addr >= 32'(4 * (2**AW)));
                    e_data = e_err ? 32'h0 : mem[addr[AW+1:2]];
                    q[k].push_back('{due: cyc + int'(LAT_P[k]), err: e_err, data: e_data});
                end
            end
        end
        if (lwe) mem[laddr] = lwdata;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        step();
        lwe = 1'b1; laddr = a; lwdata = d;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        rst_n = 1'b0; req = 1'b0; addr = '0; stall = 1'b0;
        lwe = 1'b0; laddr = '0; lwdata = '0;

        repeat (2) @(posedge clk);
        #3;
        for (int k = 0; k < NI; k++) begin
            chk1("reset_rvalid", rv_v[k], 1'b0);
            chk32("reset_rdata", rd_v[k], 32'h0);
        end
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) load(AW'(i), prog[i]);
        load(AW'(5), 32'hAAAA_5555);

        // Basic fetch on the LATENCY=1 instance
        step(); lwe = 1'b0; req = 1'b1; addr = 32'h0; #2;
        chk1("basic_gnt", gnt_v[0], 1'b1);
        step(); req = 1'b0; #2;
        chk1("basic_rvalid", rv_v[0], 1'b1);
        chk32("basic_rdata", rd_v[0], 32'h0000_0013);
        chk1("basic_err", err_v[0], 1'b0);
        drain(6);

        // Streaming on the LATENCY=2 / MAX_OUTSTANDING=2 instance
        for (int i = 0; i < 8; i++) begin
            step(); req = (i < 4); addr = 32'(4 * i); #2;
            if (i < 4) chk1("stream_gnt", gnt_v[1], 1'b1);
            chk1("stream_rvalid", rv_v[1], (i >= 2 && i <= 5));
            if (i >= 2 && i <= 5) chk32("stream_rdata", rd_v[1], prog[i-2]);
        end
        drain(6);

        // Saturation on the LATENCY=3 / MAX_OUTSTANDING=1 instance
        for (int i = 0; i < 9; i++) begin
            step(); req = 1'b1; addr = 32'h0; #2;
            chk1("sat_gnt", gnt_v[2], (i % 3 == 0));
        end
        step();
        drain(6);

        // Misaligned and out-of-range fetches back to back
        step(); req = 1'b1; addr = 32'h0000_0002; #2;
        chk1("err_gnt0", gnt_v[0], 1'b1);
        step(); addr = 32'h0000_4000; #2;
        chk1("err_gnt1", gnt_v[0], 1'b1);
        chk1("err_rvalid0", rv_v[0], 1'b1);
        chk1("err_err0", err_v[0], 1'b1);
        chk32("err_rdata0", rd_v[0], 32'h0);
        step(); req = 1'b0; #2;
        chk1("err_rvalid1", rv_v[0], 1'b1);
        chk1("err_err1", err_v[0], 1'b1);
        chk32("err_rdata1", rd_v[0], 32'h0);
        drain(6);

        // Fetch idx 5, then load idx 5 while the request is still held
        step(); req = 1'b1; addr = 32'h0000_0014; #2;
        chk1("ld_gnt_pre", gnt_v[0], 1'b1);
        step(); lwe = 1'b1; laddr = AW'(5); lwdata = 32'hDEAD_BEEF; #2;
        for (int k = 0; k < NI; k++) chk1("ld_gnt_blocked", gnt_v[k], 1'b0);
        chk1("ld_old_rvalid", rv_v[0], 1'b1);
        chk32("ld_old_rdata", rd_v[0], 32'hAAAA_5555);
        step(); lwe = 1'b0;
        drain(6);
        step(); req = 1'b1; addr = 32'h0000_0014; #2;
        step(); req = 1'b0; #2;
        chk32("ld_new_rdata", rd_v[0], 32'hDEAD_BEEF);
        drain(6);

        // Reset while two fetches are in flight on the LATENCY=3 instances
        step(); req = 1'b1; addr = 32'h0000_0004; #2;
        chk1("rst_gnt0", gnt_v[3], 1'b1);
        step(); addr = 32'h0000_0008; #2;
        chk1("rst_gnt1", gnt_v[3], 1'b1);
        step(); req = 1'b0; rst_n = 1'b0; #2;
        chk1("rst_rvalid_during", rv_v[3], 1'b0);
        step(); rst_n = 1'b1; #2;
        chk1("rst_rvalid_after", rv_v[3], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk1("rst_rvalid_later", rv_v[3], 1'b0);
        end
        step(); req = 1'b1; addr = 32'h0; #2;
        chk1("rst_next_gnt", gnt_v[3], 1'b1);
        chk1("rst_next_gnt_m1", gnt_v[2], 1'b1);
        step(); req = 1'b0;
        step();
        step(); #2;
        chk1("rst_next_rvalid", rv_v[3], 1'b1);
        chk32("rst_next_rdata", rd_v[3], 32'h0000_0013);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
